// File: rtl/decode_issue_ctrl_pkg.sv
// Shared constants, scoreboard entry layout and decoder instruction-type codes
// for the decode/issue control slice.
package decode_issue_ctrl_pkg;

   localparam int NUM_REGS_DEF  = 32;
   localparam int ROB_DEPTH_DEF = 16;
   localparam int IDX_W_DEF     = $clog2(ROB_DEPTH_DEF);
   localparam int REG_W         = 5;

   typedef struct packed {
      logic                 pending;
      logic                 is_load;
      logic [IDX_W_DEF-1:0] tag;
   } sb_entry_t;

   // Encodings shared with the decoder; only NO_WB skips ROB allocation.
   typedef enum logic [1:0] {
      NO_WB   = 2'd0,
      ALU_WB  = 2'd1,
      LOAD_WB = 2'd2,
      CSR_WB  = 2'd3
   } instr_type_e;

   function automatic logic needs_rob(instr_type_e t);
      return t != NO_WB;
   endfunction

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Per-register scoreboard tracking the ROB tag of each outstanding producer.
// Entry 0 is hardwired idle; an issue write wins over a same-cycle completion.
module issue_scoreboard
   import decode_issue_ctrl_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int IDX_W    = IDX_W_DEF
)(
   input  logic             clk,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             set_en_i,
   input  logic [REG_W-1:0] set_idx_i,
   input  logic             set_is_load_i,
   input  logic [IDX_W-1:0] set_tag_i,
   input  logic             clr_en_i,
   input  logic [IDX_W-1:0] clr_tag_i,
   input  logic [REG_W-1:0] rd1_idx_i,
   input  logic [REG_W-1:0] rd2_idx_i,
   output logic             rd1_load_pending_o,
   output logic [IDX_W-1:0] rd1_tag_o,
   output logic             rd2_load_pending_o,
   output logic [IDX_W-1:0] rd2_tag_o
);

   logic [NUM_REGS-1:0]            pending_q, pending_d;
   logic [NUM_REGS-1:0]            is_load_q, is_load_d;
   logic [NUM_REGS-1:0][IDX_W-1:0] tag_q, tag_d;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pending_q <= '0;
         is_load_q <= '0;
         tag_q     <= '0;
      end else begin
         pending_q <= pending_d;
         is_load_q <= is_load_d;
         tag_q     <= tag_d;
      end
   end

   always_comb begin
      pending_d = pending_q;
      is_load_d = is_load_q;
      tag_d     = tag_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (flush_i) begin
            pending_d[r] = 1'b0;
         end else if (set_en_i && int'(set_idx_i) == r) begin
            pending_d[r] = 1'b1;
            is_load_d[r] = set_is_load_i;
            tag_d[r]     = set_tag_i;
         end else if (clr_en_i && tag_q[r] == clr_tag_i) begin
            pending_d[r] = 1'b0;
         end
      end
      pending_d[0] = 1'b0;
      is_load_d[0] = 1'b0;
      tag_d[0]     = '0;
   end

   always_comb begin
      rd1_load_pending_o = 1'b0;
      rd1_tag_o          = '0;
      rd2_load_pending_o = 1'b0;
      rd2_tag_o          = '0;
      if (int'(rd1_idx_i) < NUM_REGS) begin
         rd1_load_pending_o = pending_q[rd1_idx_i] && is_load_q[rd1_idx_i];
         rd1_tag_o          = tag_q[rd1_idx_i];
      end
      if (int'(rd2_idx_i) < NUM_REGS) begin
         rd2_load_pending_o = pending_q[rd2_idx_i] && is_load_q[rd2_idx_i];
         rd2_tag_o          = tag_q[rd2_idx_i];
      end
   end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue control: load-use hazard detection through the
// scoreboard, circular ROB tag allocation with occupancy, and PC/IF-ID stall.
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int NUM_REGS  = NUM_REGS_DEF,
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int IDX_W     = $clog2(ROB_DEPTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic             in_uses_rs1,
   input  logic             in_uses_rs2,
   input  logic             in_writes_rd,
   input  logic             in_is_load,
   input  logic             in_allocate,
   input  logic             in_ex_ready,
   input  logic             in_complete_valid,
   input  logic [IDX_W-1:0] in_complete_idx,
   input  logic             in_commit,
   input  logic             in_flush,
   output logic             out_issue,
   output logic [IDX_W-1:0] out_allocate_idx,
   output logic             out_stall,
   output logic             out_pc_write_disable,
   output logic             out_IFID_write_disable,
   output logic [IDX_W-1:0] out_rs1_tag,
   output logic [IDX_W-1:0] out_rs2_tag,
   output logic [IDX_W:0]   out_rob_count,
   output logic             out_rob_full,
   output logic             out_rob_empty
);

   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;

   logic rs1_load_pending, rs2_load_pending;
   logic hazard, alloc_fire, commit_fire, sb_set_en;

   issue_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_scoreboard (
      .clk                (clk),
      .rst_n_i            (reset),
      .flush_i            (in_flush),
      .set_en_i           (sb_set_en),
      .set_idx_i          (in_rd),
      .set_is_load_i      (in_is_load),
      .set_tag_i          (tail_q),
      .clr_en_i           (in_complete_valid),
      .clr_tag_i          (in_complete_idx),
      .rd1_idx_i          (in_rs1),
      .rd2_idx_i          (in_rs2),
      .rd1_load_pending_o (rs1_load_pending),
      .rd1_tag_o          (out_rs1_tag),
      .rd2_load_pending_o (rs2_load_pending),
      .rd2_tag_o          (out_rs2_tag)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Full/empty come from the registered count so a commit frees a slot
   // only on the following cycle.
   assign out_rob_full  = (count_q == (IDX_W+1)'(ROB_DEPTH));
   assign out_rob_empty = (count_q == '0);
   assign out_rob_count = count_q;
   assign out_allocate_idx = tail_q;

   always_comb begin
      hazard    = (in_uses_rs1 && rs1_load_pending) || (in_uses_rs2 && rs2_load_pending);
      out_stall = reset && in_valid && (hazard || (in_allocate && out_rob_full) || !in_ex_ready);
      out_issue = reset && in_valid && !out_stall && !in_flush;
      out_pc_write_disable   = out_stall;
      out_IFID_write_disable = out_stall;
      alloc_fire  = out_issue && in_allocate;
      commit_fire = in_commit && !out_rob_empty && !in_flush;
      sb_set_en   = alloc_fire && in_writes_rd && (in_rd != '0);
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (in_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_fire)  tail_d = tail_q + 1'b1;
         if (commit_fire) head_d = head_q + 1'b1;
         case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   commit_while_empty: assert property (@(posedge clk) disable iff (!reset)
      !(in_commit && !in_flush && out_rob_empty));

endmodule
